sad_candidate_scanner: RTL and testbench

- Streams pixel pairs for consecutive candidate blocks and accumulates the sum of absolute differences (SAD) per candidate.
- Emits one (index, value, signal) record per candidate to the downstream minimum-tracking stage. That stage compares the 9-bit value against its running minimum, so the scanner saturates each SAD to 9'h0FF.
- The scanner is the producer; the minimum tracker is the sole consumer of OutIndex/OutValue/OutSignal.

---
 rtl/scanner_pkg.sv | 8 +
 rtl/abs_diff.sv | 10 +
 rtl/sad_candidate_scanner.sv | 130 +++++++++++++
 tb/tb_sad_candidate_scanner.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scanner_pkg.sv
// Shared types and constants for the SAD candidate scanner and its consumers.
package scanner_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, EMIT, DONE} state_e;

  localparam int OUT_VAL_W = 9;
  localparam int IDX_W = 16;
  localparam logic [OUT_VAL_W-1:0] SAT_MAX = 9'h0FF;
endpackage

// File: rtl/abs_diff.sv
// Unsigned absolute difference of two pixels.
module abs_diff #(
  parameter int PIX_W = 8
) (
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  output logic [PIX_W-1:0] diff_o
);
  assign diff_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);
endmodule

// File: rtl/sad_candidate_scanner.sv
// Accumulates a saturated SAD per candidate block and hands one registered
// (index, value, strobe) record per candidate to the minimum tracker.
module sad_candidate_scanner
  import scanner_pkg::*;
#(
  parameter int N_PIX = 4,
  parameter int PIX_W = 8
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Start,
  input  logic [IDX_W-1:0]     NumCand,
  input  logic                 PixValid,
  input  logic [PIX_W-1:0]     PixA,
  input  logic [PIX_W-1:0]     PixB,
  output logic                 PixReady,
  output logic [IDX_W-1:0]     OutIndex,
  output logic [OUT_VAL_W-1:0] OutValue,
  output logic                 OutSignal,
  output logic                 Busy,
  output logic                 Done
);
  localparam int ACC_W  = PIX_W + $clog2(N_PIX + 1);
  localparam int PCNT_W = $clog2(N_PIX + 1);

  state_e                 state_q;
  logic [ACC_W-1:0]       acc_q;
  logic [PCNT_W-1:0]      pix_q;
  logic [IDX_W-1:0]       cand_q;
  logic [IDX_W-1:0]       numCand_q;
  logic                   pixReady_q;
  logic [IDX_W-1:0]       outIndex_q;
  logic [OUT_VAL_W-1:0]   outValue_q;
  logic                   outSignal_q;
  logic                   busy_q;
  logic                   done_q;

  logic [PIX_W-1:0]       diff;
  logic [ACC_W-1:0]       accSum_d;
  logic [OUT_VAL_W-1:0]   satValue_d;

  abs_diff #(.PIX_W(PIX_W)) u_abs_diff (
    .a_i    (PixA),
    .b_i    (PixB),
    .diff_o (diff)
  );

  // The saturated value is taken from the sum including the final pair, so the
  // record is ready to register on the same edge that transfers that pair.
  assign accSum_d   = acc_q + ACC_W'(diff);
  assign satValue_d = (accSum_d > ACC_W'(SAT_MAX)) ? SAT_MAX : OUT_VAL_W'(accSum_d);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      pix_q       <= '0;
      cand_q      <= '0;
      numCand_q   <= '0;
      pixReady_q  <= 1'b0;
      outIndex_q  <= '0;
      outValue_q  <= '0;
      outSignal_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      outSignal_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            busy_q <= 1'b1;
            if (NumCand != '0) begin
              numCand_q  <= NumCand;
              acc_q      <= '0;
              pix_q      <= '0;
              cand_q     <= '0;
              pixReady_q <= 1'b1;
              state_q    <= ACCUM;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        ACCUM: begin
          if (PixValid) begin
            acc_q <= accSum_d;
            pix_q <= pix_q + PCNT_W'(1);
            if (pix_q == PCNT_W'(N_PIX - 1)) begin
              pixReady_q  <= 1'b0;
              outSignal_q <= 1'b1;
              outIndex_q  <= cand_q;
              outValue_q  <= satValue_d;
              state_q     <= EMIT;
            end
          end
        end
        EMIT: begin
          cand_q <= cand_q + IDX_W'(1);
          acc_q  <= '0;
          pix_q  <= '0;
          if (cand_q == numCand_q - IDX_W'(1)) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            pixReady_q <= 1'b1;
            state_q    <= ACCUM;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q     <= 1'b0;
          pixReady_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign PixReady  = pixReady_q;
  assign OutIndex  = outIndex_q;
  assign OutValue  = outValue_q;
  assign OutSignal = outSignal_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
endmodule

// File: tb/tb_sad_candidate_scanner.sv
// Randomised, self-checking bench for sad_candidate_scanner against a per-candidate SAD model.
module tb_sad_candidate_scanner;
  localparam int N_PIX = 4;
  localparam int PIX_W = 8;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Start;
  logic [15:0] NumCand;
  logic        PixValid;
  logic [7:0]  PixA;
  logic [7:0]  PixB;
  logic        PixReady;
  logic [15:0] OutIndex;
  logic [8:0]  OutValue;
  logic        OutSignal;
  logic        Busy;
  logic        Done;

  int nChecks = 0;
  int nPass = 0;
  int cycle = 0;
  int busyNotReady = 0;

  int strobeIdx[$];
  int strobeVal[$];
  int strobeCyc[$];
  int doneCyc[$];

  logic [7:0] refA[64];
  logic [7:0] refB[64];

  sad_candidate_scanner #(.N_PIX(N_PIX), .PIX_W(PIX_W)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .NumCand   (NumCand),
    .PixValid  (PixValid),
    .PixA      (PixA),
    .PixB      (PixB),
    .PixReady  (PixReady),
    .OutIndex  (OutIndex),
    .OutValue  (OutValue),
    .OutSignal (OutSignal),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cycle <= cycle + 1;

  // Record every strobe and Done pulse, sampled half a cycle after the edge
  always @(negedge Clk) begin
    if (OutSignal) begin
      strobeIdx.push_back(int'(OutIndex));
      strobeVal.push_back(int'(OutValue));
      strobeCyc.push_back(cycle);
    end
    if (Done) doneCyc.push_back(cycle);
    if (Busy && !PixReady) busyNotReady++;
  end

  function automatic int exp_sad(input int c);
    int s = 0;
    for (int p = 0; p < N_PIX; p++) begin
      int a = int'(refA[c*N_PIX+p]);
      int b = int'(refB[c*N_PIX+p]);
      s += (a > b) ? a - b : b - a;
    end
    return (s > 255) ? 255 : s;
  endfunction

  task automatic clear_log();
    strobeIdx.delete();
    strobeVal.delete();
    strobeCyc.delete();
    doneCyc.delete();
  endtask

  task automatic start_scan(input int nc);
    @(negedge Clk);
    NumCand = 16'(nc);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    NumCand = 16'($urandom);
  endtask

  // mode 0: PixValid held high, 1: toggling, 2: random gaps
  task automatic drive_scan(input int npairs, input int mode, input bit midStart);
    int k = 0;
    int guard = 0;
    bit toggle = 1'b0;
    while (k < npairs && guard < 2000) begin
      @(negedge Clk);
      guard++;
      if ((mode == 1 && toggle) || (mode == 2 && $urandom_range(0, 3) == 0)) begin
        PixValid = 1'b0;
      end else begin
        PixValid = 1'b1;
        PixA = refA[k];
        PixB = refB[k];
      end
      toggle = ~toggle;
      if (midStart) begin
        Start = (guard == 3);
        NumCand = 16'($urandom);
      end
      if (PixValid && PixReady) k++;
    end
    @(negedge Clk);
    PixValid = 1'b0;
    Start = 1'b0;
    nChecks++;
    if (k != npairs) $display("FAIL drive_timeout: transferred %0d of %0d pairs", k, npairs);
    else nPass++;
  endtask

  task automatic wait_done(input string name);
    int g = 0;
    int n0 = doneCyc.size();
    while (doneCyc.size() == n0 && g < 300) begin
      @(negedge Clk);
      #1;
      g++;
    end
    nChecks++;
    if (doneCyc.size() == n0) $display("FAIL %s_done_timeout: no Done within %0d cycles", name, g);
    else nPass++;
  endtask

  task automatic check_records(input string name, input int nc);
    nChecks++;
    if (strobeIdx.size() != nc) $display("FAIL %s_count: got %0d strobes, expected %0d", name, strobeIdx.size(), nc);
    else nPass++;
    for (int i = 0; i < nc && i < strobeIdx.size(); i++) begin
      nChecks++;
      if (strobeIdx[i] != i) $display("FAIL %s_index[%0d]: got %0d, expected %0d", name, i, strobeIdx[i], i);
      else nPass++;
      nChecks++;
      if (strobeVal[i] != exp_sad(i)) $display("FAIL %s_value[%0d]: got %0d, expected %0d", name, i, strobeVal[i], exp_sad(i));
      else nPass++;
    end
    if (strobeCyc.size() == nc && nc > 0 && doneCyc.size() > 0) begin
      nChecks++;
      if (doneCyc[0] - strobeCyc[nc-1] != 1)
        $display("FAIL %s_done_latency: got %0d cycles after last strobe, expected 1", name, doneCyc[0] - strobeCyc[nc-1]);
      else nPass++;
    end
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      Start = 1'($urandom);
      NumCand = 16'($urandom);
      PixValid = 1'($urandom);
      PixA = 8'($urandom);
      PixB = 8'($urandom);
      #1;
      nChecks++;
      if ({PixReady, OutIndex, OutValue, OutSignal, Busy, Done} !== '0)
        $display("FAIL reset_outputs: got ready=%b idx=%0d val=%0d sig=%b busy=%b done=%b, expected all 0",
                 PixReady, OutIndex, OutValue, OutSignal, Busy, Done);
      else nPass++;
    end
    Start = 1'b0;
    PixValid = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b1;
    clear_log();
    repeat (5) @(negedge Clk);
    nChecks++;
    if (Busy !== 1'b0 || PixReady !== 1'b0 || strobeIdx.size() != 0 || doneCyc.size() != 0)
      $display("FAIL reset_idle: busy=%b ready=%b strobes=%0d dones=%0d, expected 0", Busy, PixReady, strobeIdx.size(), doneCyc.size());
    else nPass++;
  endtask

  task automatic test_single();
    int a[4] = '{10, 20, 30, 40};
    int b[4] = '{12, 15, 30, 50};
    for (int i = 0; i < 4; i++) begin
      refA[i] = 8'(a[i]);
      refB[i] = 8'(b[i]);
    end
    clear_log();
    start_scan(1);
    nChecks++;
    if (PixReady !== 1'b1 || Busy !== 1'b1) $display("FAIL single_start: ready=%b busy=%b, expected 1 1", PixReady, Busy);
    else nPass++;
    drive_scan(4, 0, 1'b0);
    wait_done("single");
    nChecks++;
    if (strobeVal.size() != 1 || strobeVal[0] != 17)
      $display("FAIL single_value: got %0d strobes, value %0d, expected 1 strobe value 17", strobeVal.size(),
               (strobeVal.size() > 0) ? strobeVal[0] : -1);
    else nPass++;
    check_records("single", 1);
    @(negedge Clk);
    nChecks++;
    if (Busy !== 1'b0 || Done !== 1'b0) $display("FAIL single_busy_fall: busy=%b done=%b, expected 0 0", Busy, Done);
    else nPass++;
  endtask

  task automatic test_saturation();
    for (int p = 0; p < 4; p++) begin
      refA[p] = 8'd255;  refB[p] = 8'd0;
      refA[4+p] = 8'(37 * p + 5);  refB[4+p] = 8'(37 * p + 5);
      refA[8+p] = 8'(p * 10);  refB[8+p] = 8'(p * 10 + 64);
    end
    clear_log();
    start_scan(3);
    drive_scan(12, 0, 1'b0);
    wait_done("sat");
    check_records("sat", 3);
    if (strobeCyc.size() == 3) begin
      for (int i = 1; i < 3; i++) begin
        nChecks++;
        if (strobeCyc[i] - strobeCyc[i-1] != N_PIX + 1)
          $display("FAIL sat_spacing[%0d]: got %0d cycles, expected %0d", i, strobeCyc[i] - strobeCyc[i-1], N_PIX + 1);
        else nPass++;
      end
    end
  endtask

  task automatic test_stalls();
    for (int k = 0; k < 8; k++) begin
      refA[k] = 8'($urandom);
      refB[k] = 8'($urandom);
    end
    @(negedge Clk);
    clear_log();
    busyNotReady = 0;
    start_scan(2);
    drive_scan(8, 1, 1'b1);
    wait_done("stall");
    check_records("stall", 2);
    nChecks++;
    if (doneCyc.size() != 1) $display("FAIL stall_done_count: got %0d, expected 1", doneCyc.size());
    else nPass++;
    @(negedge Clk);
    #1;
    nChecks++;
    if (busyNotReady != 3) $display("FAIL stall_not_ready_cycles: got %0d busy-not-ready cycles, expected 3", busyNotReady);
    else nPass++;
  endtask

  task automatic test_empty();
    int holdVal = exp_sad(1);
    clear_log();
    start_scan(0);
    nChecks++;
    if (Done !== 1'b1 || Busy !== 1'b1) $display("FAIL empty_done: done=%b busy=%b, expected 1 1", Done, Busy);
    else nPass++;
    repeat (3) @(negedge Clk);
    #1;
    nChecks++;
    if (strobeIdx.size() != 0 || doneCyc.size() != 1 || Busy !== 1'b0)
      $display("FAIL empty_quiet: strobes=%0d dones=%0d busy=%b, expected 0 1 0", strobeIdx.size(), doneCyc.size(), Busy);
    else nPass++;
    nChecks++;
    if (OutIndex !== 16'd1 || OutValue !== 9'(holdVal))
      $display("FAIL empty_hold: idx=%0d val=%0d, expected 1 %0d", OutIndex, OutValue, holdVal);
    else nPass++;
  endtask

  task automatic test_midscan_reset();
    for (int k = 0; k < 12; k++) begin
      refA[k] = 8'($urandom);
      refB[k] = 8'($urandom);
    end
    clear_log();
    start_scan(3);
    drive_scan(N_PIX + 2, 0, 1'b0);
    #1;
    nChecks++;
    if (strobeIdx.size() != 1) $display("FAIL midrst_pre_strobes: got %0d, expected 1", strobeIdx.size());
    else nPass++;
    Rst_n = 1'b0;
    #1;
    nChecks++;
    if (Busy !== 1'b0 || PixReady !== 1'b0 || OutValue !== 9'd0 || OutIndex !== 16'd0)
      $display("FAIL midrst_async: busy=%b ready=%b val=%0d idx=%0d, expected all 0", Busy, PixReady, OutValue, OutIndex);
    else nPass++;
    @(negedge Clk);
    Rst_n = 1'b1;
    clear_log();
    repeat (3) @(negedge Clk);
    #1;
    nChecks++;
    if (strobeIdx.size() != 0 || doneCyc.size() != 0)
      $display("FAIL midrst_no_strobe: strobes=%0d dones=%0d, expected 0 0", strobeIdx.size(), doneCyc.size());
    else nPass++;
    for (int k = 0; k < 4; k++) begin
      refA[k] = 8'($urandom_range(0, 100));
      refB[k] = 8'($urandom_range(0, 100));
    end
    start_scan(1);
    drive_scan(4, 0, 1'b0);
    wait_done("midrst_fresh");
    check_records("midrst_fresh", 1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int nc = $urandom_range(1, 5);
      for (int k = 0; k < nc * N_PIX; k++) begin
        int base = $urandom_range(0, 255);
        int d = $urandom_range(0, 127);
        refA[k] = 8'(base);
        refB[k] = 8'((r % 2 == 0) ? $urandom : (base + d));
      end
      @(negedge Clk);
      clear_log();
      start_scan(nc);
      drive_scan(nc * N_PIX, 2, 1'b0);
      wait_done("random");
      check_records("random", nc);
    end
  endtask

  initial begin
    Rst_n = 1'b0;
    Start = 1'b0;
    NumCand = '0;
    PixValid = 1'b0;
    PixA = '0;
    PixB = '0;
    test_reset();
    test_single();
    test_saturation();
    test_stalls();
    test_empty();
    test_midscan_reset();
    test_random();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
